decode_exec_pipe: RTL and testbench

Parametrised decode-to-execute pipeline register for the 18-bit pipelined core, generalising the fixed three-port D/E latch. It sits between register-file read and the execute stage. It captures N source operands plus a packed control bundle, and applies write-back bypass at capture and while held. It detects load-use hazards against the instruction in E and inserts bubbles, honours downstream stall and branch flush, and keeps saturating bubble/flush counters.

---
 rtl/decode_exec_pipe.sv | 178 +++++++++++++++++
 tb/tb_decode_exec_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_exec_pipe.sv
`default_nettype none
// ============================================================================
// decode_exec_pipe : D->E pipeline register with write-back bypass, load-use
//                    bubble insertion, stall/flush handling and event counters
// Revision: 1.0
// ============================================================================
module decode_exec_pipe #(
  parameter int unsigned DATA_W   = 18,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned PC_W     = 9,
  parameter int unsigned NPORTS   = 3,
  parameter int unsigned CTRL_W   = 16,
  parameter int unsigned CNT_W    = 16,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_d,
  input  logic [CTRL_W-1:0]        ctrl_d,
  input  logic [NPORTS*ADDR_W-1:0] rs_d,
  input  logic [NPORTS-1:0]        rs_en_d,
  input  logic [NPORTS*DATA_W-1:0] rf_data_d,
  input  logic [ADDR_W-1:0]        rd_d,
  input  logic                     load_d,
  input  logic [DATA_W-1:0]        imm_d,
  input  logic [PC_W-1:0]          pc_d,
  input  logic [PC_W-1:0]          pcplus_d,
  input  logic                     regwrite_w,
  input  logic [ADDR_W-1:0]        rd_w,
  input  logic [DATA_W-1:0]        result_w,
  input  logic                     stall_e,
  input  logic                     flush_e,
  output logic                     valid_e,
  output logic [CTRL_W-1:0]        ctrl_e,
  output logic [NPORTS*ADDR_W-1:0] rs_e,
  output logic [NPORTS-1:0]        rs_en_e,
  output logic [NPORTS*DATA_W-1:0] data_e,
  output logic [ADDR_W-1:0]        rd_e,
  output logic                     load_e,
  output logic [DATA_W-1:0]        imm_e,
  output logic [PC_W-1:0]          pc_e,
  output logic [PC_W-1:0]          pcplus_e,
  output logic                     stall_d,
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  localparam int unsigned c_ops_w = NPORTS * DATA_W;
  localparam int unsigned c_idx_w = NPORTS * ADDR_W;

  // Register 0 is hard-wired when ZERO_REG, so it can never be a producer.
  function automatic logic reg_match(input logic en, input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] b);
    return en && (a == b) && !(ZERO_REG && (a == '0));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic                 valid_e_q,    valid_e_d;
  logic [CTRL_W-1:0]    ctrl_e_q,     ctrl_e_d;
  logic [c_idx_w-1:0]   rs_e_q,       rs_e_d;
  logic [NPORTS-1:0]    rs_en_e_q,    rs_en_e_d;
  logic [c_ops_w-1:0]   data_e_q,     data_e_d;
  logic [ADDR_W-1:0]    rd_e_q,       rd_e_d;
  logic                 load_e_q,     load_e_d;
  logic [DATA_W-1:0]    imm_e_q,      imm_e_d;
  logic [PC_W-1:0]      pc_e_q,       pc_e_d;
  logic [PC_W-1:0]      pcplus_e_q,   pcplus_e_d;
  logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q,  flush_cnt_d;

  logic [c_ops_w-1:0]   w_cap_data;
  logic [c_ops_w-1:0]   w_hold_data;
  logic [NPORTS-1:0]    w_lu_port;
  logic                 w_lu;

  generate
    for (genvar i = 0; i < NPORTS; i++) begin : g_port
      assign w_cap_data[i*DATA_W +: DATA_W] =
        reg_match(regwrite_w, rd_w, rs_d[i*ADDR_W +: ADDR_W]) ?
        result_w : rf_data_d[i*DATA_W +: DATA_W];
      assign w_hold_data[i*DATA_W +: DATA_W] =
        reg_match(regwrite_w && rs_en_e_q[i], rd_w, rs_e_q[i*ADDR_W +: ADDR_W]) ?
        result_w : data_e_q[i*DATA_W +: DATA_W];
      assign w_lu_port[i] = reg_match(rs_en_d[i], rd_e_q, rs_d[i*ADDR_W +: ADDR_W]);
    end
  endgenerate

  assign w_lu    = valid_e_q && load_e_q && !flush_e && (|w_lu_port);
  assign stall_d = (valid_d && w_lu) || (stall_e && !flush_e);

  always_comb begin
    valid_e_d    = valid_e_q;
    ctrl_e_d     = ctrl_e_q;
    rs_e_d       = rs_e_q;
    rs_en_e_d    = rs_en_e_q;
    data_e_d     = data_e_q;
    rd_e_d       = rd_e_q;
    load_e_d     = load_e_q;
    imm_e_d      = imm_e_q;
    pc_e_d       = pc_e_q;
    pcplus_e_d   = pcplus_e_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (flush_e) begin
      valid_e_d = 1'b0;
      ctrl_e_d  = '0;
      load_e_d  = 1'b0;
      if (valid_e_q) flush_cnt_d = sat_inc(flush_cnt_q);
    end else if (stall_e) begin
      data_e_d = w_hold_data;
    end else if (w_lu && valid_d) begin
      valid_e_d    = 1'b0;
      ctrl_e_d     = '0;
      load_e_d     = 1'b0;
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end else begin
      valid_e_d  = valid_d;
      ctrl_e_d   = valid_d ? ctrl_d : '0;
      rs_e_d     = rs_d;
      rs_en_e_d  = rs_en_d;
      data_e_d   = w_cap_data;
      rd_e_d     = rd_d;
      load_e_d   = load_d;
      imm_e_d    = imm_d;
      pc_e_d     = pc_d;
      pcplus_e_d = pcplus_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_e_q    <= 1'b0;
      ctrl_e_q     <= '0;
      rs_e_q       <= '0;
      rs_en_e_q    <= '0;
      data_e_q     <= '0;
      rd_e_q       <= '0;
      load_e_q     <= 1'b0;
      imm_e_q      <= '0;
      pc_e_q       <= '0;
      pcplus_e_q   <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      valid_e_q    <= valid_e_d;
      ctrl_e_q     <= ctrl_e_d;
      rs_e_q       <= rs_e_d;
      rs_en_e_q    <= rs_en_e_d;
      data_e_q     <= data_e_d;
      rd_e_q       <= rd_e_d;
      load_e_q     <= load_e_d;
      imm_e_q      <= imm_e_d;
      pc_e_q       <= pc_e_d;
      pcplus_e_q   <= pcplus_e_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign valid_e    = valid_e_q;
  assign ctrl_e     = ctrl_e_q;
  assign rs_e       = rs_e_q;
  assign rs_en_e    = rs_en_e_q;
  assign data_e     = data_e_q;
  assign rd_e       = rd_e_q;
  assign load_e     = load_e_q;
  assign imm_e      = imm_e_q;
  assign pc_e       = pc_e_q;
  assign pcplus_e   = pcplus_e_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_exec_pipe.sv
`default_nettype none
// ============================================================================
// tb_decode_exec_pipe : scoreboard bench for decode_exec_pipe (CNT_W=4)
// Revision: 1.0
// ============================================================================
module tb_decode_exec_pipe;
  localparam int DW = 18;
  localparam int AW = 5;
  localparam int PW = 9;
  localparam int NP = 3;
  localparam int CW = 16;
  localparam int KW = 4;

  logic clk = 1'b0;
  logic rst;
  logic valid_d, load_d, regwrite_w, stall_e, flush_e;
  logic [CW-1:0] ctrl_d;
  logic [NP*AW-1:0] rs_d;
  logic [NP-1:0] rs_en_d;
  logic [NP*DW-1:0] rf_data_d;
  logic [AW-1:0] rd_d, rd_w;
  logic [DW-1:0] imm_d, result_w;
  logic [PW-1:0] pc_d, pcplus_d;
  logic valid_e, load_e, stall_d;
  logic [CW-1:0] ctrl_e;
  logic [NP*AW-1:0] rs_e;
  logic [NP-1:0] rs_en_e;
  logic [NP*DW-1:0] data_e;
  logic [AW-1:0] rd_e;
  logic [DW-1:0] imm_e;
  logic [PW-1:0] pc_e, pcplus_e;
  logic [KW-1:0] bubble_cnt, flush_cnt;

  decode_exec_pipe #(
    .DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .NPORTS(NP),
    .CTRL_W(CW), .CNT_W(KW), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .ctrl_d(ctrl_d), .rs_d(rs_d),
    .rs_en_d(rs_en_d), .rf_data_d(rf_data_d), .rd_d(rd_d), .load_d(load_d),
    .imm_d(imm_d), .pc_d(pc_d), .pcplus_d(pcplus_d), .regwrite_w(regwrite_w),
    .rd_w(rd_w), .result_w(result_w), .stall_e(stall_e), .flush_e(flush_e),
    .valid_e(valid_e), .ctrl_e(ctrl_e), .rs_e(rs_e), .rs_en_e(rs_en_e),
    .data_e(data_e), .rd_e(rd_e), .load_e(load_e), .imm_e(imm_e), .pc_e(pc_e),
    .pcplus_e(pcplus_e), .stall_d(stall_d), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [CW-1:0] ctrl;
    logic          load;
    logic          chk;
    logic [NP*DW-1:0] data;
    logic [AW-1:0] rd;
    logic [PW-1:0] pc;
    logic [KW-1:0] bub;
    logic [KW-1:0] flu;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [KW-1:0] n_bub = '0;
  logic [KW-1:0] n_flu = '0;

  function automatic exp_t mk(input logic v, input logic [CW-1:0] c, input logic l,
                              input logic chk, input logic [NP*DW-1:0] d,
                              input logic [AW-1:0] rd, input logic [PW-1:0] pc);
    exp_t e;
    e.valid = v; e.ctrl = c; e.load = l; e.chk = chk;
    e.data = d; e.rd = rd; e.pc = pc; e.bub = n_bub; e.flu = n_flu;
    return e;
  endfunction

  task automatic idle_d();
    valid_d = 0; ctrl_d = '0; rs_d = '0; rs_en_d = '0; rf_data_d = '0;
    rd_d = '0; load_d = 0; imm_d = '0; pc_d = '0; pcplus_d = '0;
    regwrite_w = 0; rd_w = '0; result_w = '0; stall_e = 0; flush_e = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    idle_d();
    rst = 0; valid_d = 1; ctrl_d = 16'hBEEF; pc_d = 9'h1AB; rf_data_d = '1; rd_d = 5'd9;
    n_bub = '0; n_flu = '0;
    for (int c = 0; c < 2; c++) begin
      sb.push_back(mk(0, '0, 0, 1, '0, '0, '0));
      tick();
      e = sb.pop_front();
      total++;
      if ({valid_e, ctrl_e, load_e, bubble_cnt, flush_cnt} !== {e.valid, e.ctrl, e.load, e.bub, e.flu}) begin
        bad++;
        $display("FAIL reset_ctl cyc%0d: got v=%b ctrl=%h ld=%b bub=%0d flu=%0d want v=%b ctrl=%h ld=%b bub=%0d flu=%0d",
                 c, valid_e, ctrl_e, load_e, bubble_cnt, flush_cnt, e.valid, e.ctrl, e.load, e.bub, e.flu);
      end
      total++;
      if ({data_e, rd_e, pc_e} !== {e.data, e.rd, e.pc}) begin
        bad++;
        $display("FAIL reset_data cyc%0d: got data=%h rd=%0d pc=%h want data=%h rd=%0d pc=%h",
                 c, data_e, rd_e, pc_e, e.data, e.rd, e.pc);
      end
    end
    total++;
    if (stall_d !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall_d: got %b want 0", stall_d);
    end
    rst = 1;
    idle_d();
  endtask

  task automatic test_bypass();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      idle_d();
      valid_d = 1; rs_en_d = 3'b011; rd_d = 5'd12;
      rf_data_d = {18'h00222, 18'h00111, 18'h00010};
      rs_d[AW +: AW] = 5'd3; regwrite_w = 1; result_w = 18'h2ABCD;
      if (c == 0) begin
        ctrl_d = 16'h1234; pc_d = 9'h010; rs_d[0 +: AW] = 5'd7; rd_w = 5'd7;
        sb.push_back(mk(1, 16'h1234, 0, 1, {18'h00222, 18'h00111, 18'h2ABCD}, 5'd12, 9'h010));
      end else begin
        ctrl_d = 16'h1235; pc_d = 9'h011; rs_d[0 +: AW] = 5'd0; rd_w = 5'd0;
        sb.push_back(mk(1, 16'h1235, 0, 1, {18'h00222, 18'h00111, 18'h00010}, 5'd12, 9'h011));
      end
      tick();
      e = sb.pop_front();
      total++;
      if ({valid_e, ctrl_e, load_e, bubble_cnt, flush_cnt} !== {e.valid, e.ctrl, e.load, e.bub, e.flu}) begin
        bad++;
        $display("FAIL bypass_ctl%0d: got v=%b ctrl=%h ld=%b want v=%b ctrl=%h ld=%b",
                 c, valid_e, ctrl_e, load_e, e.valid, e.ctrl, e.load);
      end
      total++;
      if ({data_e, rd_e, pc_e} !== {e.data, e.rd, e.pc}) begin
        bad++;
        $display("FAIL bypass_data%0d: got data=%h rd=%0d pc=%h want data=%h rd=%0d pc=%h",
                 c, data_e, rd_e, pc_e, e.data, e.rd, e.pc);
      end
    end
    idle_d();
  endtask

  task automatic test_load_use();
    exp_t e;
    logic sd_exp;
    for (int s = 0; s < 5; s++) begin
      idle_d();
      valid_d = 1;
      case (s)
        0: begin
          load_d = 1; rd_d = 5'd4; ctrl_d = 16'h00AA; pc_d = 9'h020; sd_exp = 0;
          sb.push_back(mk(1, 16'h00AA, 1, 1, '0, 5'd4, 9'h020));
        end
        1, 2: begin
          ctrl_d = 16'h0BEE; rs_d[AW +: AW] = 5'd4; rs_en_d = 3'b010;
          rf_data_d[DW +: DW] = 18'h00200; rd_d = 5'd6; pc_d = 9'h021;
          if (s == 1) begin
            sd_exp = 1;
            n_bub = n_bub + 1'b1;
            sb.push_back(mk(0, '0, 0, 0, '0, '0, '0));
          end else begin
            sd_exp = 0; regwrite_w = 1; rd_w = 5'd4; result_w = 18'h3C0DE;
            sb.push_back(mk(1, 16'h0BEE, 0, 1, {18'h0, 18'h3C0DE, 18'h0}, 5'd6, 9'h021));
          end
        end
        3: begin
          load_d = 1; rd_d = 5'd0; ctrl_d = 16'h00AB; pc_d = 9'h022; sd_exp = 0;
          sb.push_back(mk(1, 16'h00AB, 1, 1, '0, 5'd0, 9'h022));
        end
        default: begin
          ctrl_d = 16'h0CCC; rs_en_d = 3'b001; rf_data_d[0 +: DW] = 18'h00033;
          rd_d = 5'd7; pc_d = 9'h023; sd_exp = 0;
          sb.push_back(mk(1, 16'h0CCC, 0, 1, {18'h0, 18'h0, 18'h00033}, 5'd7, 9'h023));
        end
      endcase
      #1;
      total++;
      if (stall_d !== sd_exp) begin
        bad++;
        $display("FAIL loaduse_stall_d step%0d: got %b want %b", s, stall_d, sd_exp);
      end
      tick();
      e = sb.pop_front();
      total++;
      if ({valid_e, ctrl_e, load_e, bubble_cnt, flush_cnt} !== {e.valid, e.ctrl, e.load, e.bub, e.flu}) begin
        bad++;
        $display("FAIL loaduse_ctl step%0d: got v=%b ctrl=%h ld=%b bub=%0d want v=%b ctrl=%h ld=%b bub=%0d",
                 s, valid_e, ctrl_e, load_e, bubble_cnt, e.valid, e.ctrl, e.load, e.bub);
      end
      if (e.chk) begin
        total++;
        if ({data_e, rd_e, pc_e} !== {e.data, e.rd, e.pc}) begin
          bad++;
          $display("FAIL loaduse_data step%0d: got data=%h rd=%0d pc=%h want data=%h rd=%0d pc=%h",
                   s, data_e, rd_e, pc_e, e.data, e.rd, e.pc);
        end
      end
    end
    idle_d();
  endtask

  task automatic test_hold_refresh();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      idle_d();
      valid_d = 1;
      if (s == 0) begin
        ctrl_d = 16'h0C0C; rs_d = {5'd9, 5'd2, 5'd9}; rs_en_d = 3'b100;
        rf_data_d = {18'h00001, 18'h00005, 18'h00002}; rd_d = 5'd10; pc_d = 9'h055;
        sb.push_back(mk(1, 16'h0C0C, 0, 1, {18'h00001, 18'h00005, 18'h00002}, 5'd10, 9'h055));
      end else begin
        stall_e = 1; ctrl_d = 16'hFFFF; pc_d = 9'h1FF; rd_d = 5'd3; rf_data_d = '1;
        if (s == 2) begin
          regwrite_w = 1; rd_w = 5'd9; result_w = 18'h00155;
        end
        if (s == 1)
          sb.push_back(mk(1, 16'h0C0C, 0, 1, {18'h00001, 18'h00005, 18'h00002}, 5'd10, 9'h055));
        else
          sb.push_back(mk(1, 16'h0C0C, 0, 1, {18'h00155, 18'h00005, 18'h00002}, 5'd10, 9'h055));
        #1;
        total++;
        if (stall_d !== 1'b1) begin
          bad++;
          $display("FAIL hold_stall_d step%0d: got %b want 1", s, stall_d);
        end
      end
      tick();
      e = sb.pop_front();
      total++;
      if ({valid_e, ctrl_e, load_e, data_e, rd_e, pc_e} !== {e.valid, e.ctrl, e.load, e.data, e.rd, e.pc}) begin
        bad++;
        $display("FAIL hold_refresh step%0d: got v=%b ctrl=%h data=%h rd=%0d pc=%h want v=%b ctrl=%h data=%h rd=%0d pc=%h",
                 s, valid_e, ctrl_e, data_e, rd_e, pc_e, e.valid, e.ctrl, e.data, e.rd, e.pc);
      end
    end
    idle_d();
  endtask

  task automatic test_flush();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      idle_d();
      case (s)
        0: begin
          valid_d = 1; load_d = 1; rd_d = 5'd5; ctrl_d = 16'h0F0F; pc_d = 9'h060;
          sb.push_back(mk(1, 16'h0F0F, 1, 1, '0, 5'd5, 9'h060));
        end
        1: begin
          stall_e = 1; flush_e = 1; valid_d = 1; rs_d[0 +: AW] = 5'd5; rs_en_d = 3'b001;
          n_flu = n_flu + 1'b1;
          sb.push_back(mk(0, '0, 0, 0, '0, '0, '0));
        end
        2: begin
          flush_e = 1; valid_d = 1; ctrl_d = 16'h2222;
          sb.push_back(mk(0, '0, 0, 0, '0, '0, '0));
        end
        default: begin
          valid_d = 0; ctrl_d = 16'h1111; rd_d = 5'd8; pc_d = 9'h061;
          rs_d[0 +: AW] = 5'd5; rf_data_d = {18'h0, 18'h0, 18'h00ABC};
          sb.push_back(mk(0, '0, 0, 1, {18'h0, 18'h0, 18'h00ABC}, 5'd8, 9'h061));
        end
      endcase
      #1;
      total++;
      if (stall_d !== 1'b0) begin
        bad++;
        $display("FAIL flush_stall_d step%0d: got %b want 0", s, stall_d);
      end
      tick();
      e = sb.pop_front();
      total++;
      if ({valid_e, ctrl_e, load_e, bubble_cnt, flush_cnt} !== {e.valid, e.ctrl, e.load, e.bub, e.flu}) begin
        bad++;
        $display("FAIL flush_ctl step%0d: got v=%b ctrl=%h ld=%b flu=%0d want v=%b ctrl=%h ld=%b flu=%0d",
                 s, valid_e, ctrl_e, load_e, flush_cnt, e.valid, e.ctrl, e.load, e.flu);
      end
      if (e.chk) begin
        total++;
        if ({data_e, rd_e, pc_e} !== {e.data, e.rd, e.pc}) begin
          bad++;
          $display("FAIL flush_capture step%0d: got data=%h rd=%0d pc=%h want data=%h rd=%0d pc=%h",
                   s, data_e, rd_e, pc_e, e.data, e.rd, e.pc);
        end
      end
    end
    idle_d();
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int k = 0; k < 40; k++) begin
      idle_d();
      valid_d = 1;
      if (k % 2 == 0) begin
        load_d = 1; rd_d = 5'd4; ctrl_d = 16'h0101;
        sb.push_back(mk(1, 16'h0101, 1, 0, '0, '0, '0));
      end else begin
        ctrl_d = 16'h0202; rs_d[0 +: AW] = 5'd4; rs_en_d = 3'b001;
        if (n_bub != '1) n_bub = n_bub + 1'b1;
        sb.push_back(mk(0, '0, 0, 0, '0, '0, '0));
      end
      tick();
      e = sb.pop_front();
      total++;
      if ({valid_e, ctrl_e, load_e, bubble_cnt, flush_cnt} !== {e.valid, e.ctrl, e.load, e.bub, e.flu}) begin
        bad++;
        $display("FAIL saturate k%0d: got v=%b ctrl=%h ld=%b bub=%0d flu=%0d want v=%b ctrl=%h ld=%b bub=%0d flu=%0d",
                 k, valid_e, ctrl_e, load_e, bubble_cnt, flush_cnt, e.valid, e.ctrl, e.load, e.bub, e.flu);
      end
    end
    idle_d();
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    idle_d();
    valid_d = 1; ctrl_d = 16'h0303; stall_e = 1; rst = 0;
    n_bub = '0; n_flu = '0;
    sb.push_back(mk(0, '0, 0, 1, '0, '0, '0));
    tick();
    e = sb.pop_front();
    total++;
    if ({valid_e, ctrl_e, load_e, bubble_cnt, flush_cnt, data_e, rd_e, pc_e} !==
        {e.valid, e.ctrl, e.load, e.bub, e.flu, e.data, e.rd, e.pc}) begin
      bad++;
      $display("FAIL reset_mid_stall: got v=%b ctrl=%h bub=%0d flu=%0d data=%h want all zero",
               valid_e, ctrl_e, bubble_cnt, flush_cnt, data_e);
    end
    rst = 1;
    idle_d();
  endtask

  initial begin
    rst = 0;
    idle_d();
    test_reset();
    test_bypass();
    test_load_use();
    test_hold_refresh();
    test_flush();
    test_saturation();
    test_reset_mid_stall();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
